// File: rtl/pipe_ctrl_stage_pkg.sv
// pipe_ctrl_stage_pkg
//   Shared definitions for the pipeline control stage: control-lane bit
//   positions, the default control width and the stage FSM encoding.
//   No ports.
package pipe_ctrl_stage_pkg;

  // Bit positions inside a control lane.
  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_JUMP       = 1;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_MEM_READ   = 3;
  localparam int CTRL_BRANCH     = 4;
  localparam int CTRL_ALU_SRC    = 5;
  localparam int CTRL_MEM_TO_REG = 6;
  localparam int CTRL_REG_DST    = 7;

  localparam int CTRL_W_DEF = 8;

  // Stage FSM encoding.
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

endpackage

// File: rtl/pipe_ctrl_stage_if.sv
// pipe_ctrl_stage_if
//   Bundles the pipeline stage input lanes, hazard controls and registered
//   outputs.
//   master : drives in_data/in_ctrl/sel/in_valid/stall/flush, observes outputs
//   slave  : the stage itself; consumes inputs, drives out_data/out_ctrl/
//            out_valid/flushing/bubble_cnt
interface pipe_ctrl_stage_if
  import pipe_ctrl_stage_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int NUM_IN = 2,
  parameter int SEL_W  = 1,
  parameter int CNT_W  = 16
);
  logic [NUM_IN*DATA_W-1:0] in_data;
  logic [NUM_IN*CTRL_W-1:0] in_ctrl;
  logic [SEL_W-1:0]         sel;
  logic                     in_valid;
  logic                     stall;
  logic                     flush;
  logic [DATA_W-1:0]        out_data;
  logic [CTRL_W-1:0]        out_ctrl;
  logic                     out_valid;
  logic                     flushing;
  logic [CNT_W-1:0]         bubble_cnt;

  modport master (
    output in_data, in_ctrl, sel, in_valid, stall, flush,
    input  out_data, out_ctrl, out_valid, flushing, bubble_cnt
  );

  modport slave (
    input  in_data, in_ctrl, sel, in_valid, stall, flush,
    output out_data, out_ctrl, out_valid, flushing, bubble_cnt
  );
endinterface

// File: rtl/pipe_ctrl_stage_mux_n.sv
// mux_n
//   Combinational NUM_IN-way lane selector. Lane i occupies
//   lanes_i[i*DATA_W +: DATA_W]; a select value outside 0..NUM_IN-1 falls
//   back to lane 0.
//   lanes_i : packed input lanes
//   sel_i   : lane select
//   lane_o  : selected lane
module mux_n #(
  parameter int DATA_W = 16,
  parameter int NUM_IN = 2,
  parameter int SEL_W  = 1
) (
  input  logic [NUM_IN*DATA_W-1:0] lanes_i,
  input  logic [SEL_W-1:0]         sel_i,
  output logic [DATA_W-1:0]        lane_o
);

  always_comb begin
    lane_o = lanes_i[0 +: DATA_W];
    for (int i = 1; i < NUM_IN; i++) begin
      if (int'(sel_i) == i) lane_o = lanes_i[i*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/pipe_ctrl_stage.sv
// pipe_ctrl_stage
//   Pipeline stage register (e.g. ID/EX) with a NUM_IN-way input lane mux,
//   stall (hold), multi-cycle flush that injects FLUSH_CYCLES bubbles, and a
//   saturating count of flush bubbles.
//   clk  : rising-edge clock
//   arst : asynchronous active-high reset
//   bus  : slave side of pipe_ctrl_stage_if (inputs, stall/flush, outputs)
module pipe_ctrl_stage
  import pipe_ctrl_stage_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int CTRL_W       = CTRL_W_DEF,
  parameter int NUM_IN       = 2,
  parameter int SEL_W        = $clog2(NUM_IN),
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input logic              clk,
  input logic              arst,
  pipe_ctrl_stage_if.slave bus
);

  // Holds FLUSH_CYCLES-1, the bubbles still owed after the flush edge.
  localparam int REM_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic [DATA_W-1:0] sel_data;
  logic [CTRL_W-1:0] sel_ctrl;

  logic [0:0]        state_q, state_d;
  logic [REM_W-1:0]  rem_q,   rem_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  mux_n #(.DATA_W(DATA_W), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) u_data_mux (
    .lanes_i (bus.in_data),
    .sel_i   (bus.sel),
    .lane_o  (sel_data)
  );

  mux_n #(.DATA_W(CTRL_W), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) u_ctrl_mux (
    .lanes_i (bus.in_ctrl),
    .sel_i   (bus.sel),
    .lane_o  (sel_ctrl)
  );

  // Next-state: flush beats stall beats load; FLUSH never loads inputs.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (bus.flush) begin
      ctrl_d  = '0;
      valid_d = 1'b0;
      cnt_d   = sat_inc(cnt_q);
      if (FLUSH_CYCLES == 1) begin
        state_d = ST_RUN;
        rem_d   = '0;
      end else begin
        state_d = ST_FLUSH;
        rem_d   = REM_W'(FLUSH_CYCLES - 1);
      end
    end else if (state_q == ST_FLUSH) begin
      if (!bus.stall) begin
        ctrl_d  = '0;
        valid_d = 1'b0;
        cnt_d   = sat_inc(cnt_q);
        rem_d   = rem_q - REM_W'(1);
        if (rem_q == REM_W'(1)) state_d = ST_RUN;
      end
    end else if (!bus.stall) begin
      data_d  = sel_data;
      valid_d = bus.in_valid;
      ctrl_d  = bus.in_valid ? sel_ctrl : '0;
    end
  end

  // Stage register boundary
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= ST_RUN;
      rem_q   <= '0;
      data_q  <= '0;
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.out_data   = data_q;
  assign bus.out_ctrl   = ctrl_q;
  assign bus.out_valid  = valid_q;
  assign bus.flushing   = (state_q == ST_FLUSH);
  assign bus.bubble_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_stage.sv
// tb_pipe_ctrl_stage
//   Two stage instances share one stimulus stream:
//   A: NUM_IN=4, FLUSH_CYCLES=2, CNT_W=16
//   B: NUM_IN=3, FLUSH_CYCLES=1, CNT_W=3 (out-of-range select, saturation)
//   A bubble-budget model is compared against both on every falling edge;
//   directed literal checks pin the model.
module tb_pipe_ctrl_stage;

  logic clk;
  logic arst;
  logic [15:0] ld [4];
  logic [7:0]  lc [4];
  logic [1:0]  sel;
  logic        valid, stall, flush;

  int total = 0;
  int bad   = 0;

  pipe_ctrl_stage_if #(.DATA_W(16), .CTRL_W(8), .NUM_IN(4), .SEL_W(2), .CNT_W(16)) bus_a ();
  pipe_ctrl_stage_if #(.DATA_W(16), .CTRL_W(8), .NUM_IN(3), .SEL_W(2), .CNT_W(3))  bus_b ();

  assign bus_a.in_data  = {ld[3], ld[2], ld[1], ld[0]};
  assign bus_a.in_ctrl  = {lc[3], lc[2], lc[1], lc[0]};
  assign bus_a.sel      = sel;
  assign bus_a.in_valid = valid;
  assign bus_a.stall    = stall;
  assign bus_a.flush    = flush;
  assign bus_b.in_data  = {ld[2], ld[1], ld[0]};
  assign bus_b.in_ctrl  = {lc[2], lc[1], lc[0]};
  assign bus_b.sel      = sel;
  assign bus_b.in_valid = valid;
  assign bus_b.stall    = stall;
  assign bus_b.flush    = flush;

  pipe_ctrl_stage #(.DATA_W(16), .CTRL_W(8), .NUM_IN(4), .SEL_W(2),
                    .FLUSH_CYCLES(2), .CNT_W(16)) dut_a (.clk(clk), .arst(arst), .bus(bus_a));
  pipe_ctrl_stage #(.DATA_W(16), .CTRL_W(8), .NUM_IN(3), .SEL_W(2),
                    .FLUSH_CYCLES(1), .CNT_W(3))  dut_b (.clk(clk), .arst(arst), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: each instance owes mrem bubbles; a flush resets the debt.
  int          mN   [2] = '{4, 3};
  int          mfc  [2] = '{2, 1};
  int          mmax [2] = '{65535, 7};
  logic [15:0] md   [2];
  logic [7:0]  mc   [2];
  logic        mv   [2];
  int          mrem [2];
  int          mcnt [2];

  always @(posedge clk or posedge arst) begin
    for (int k = 0; k < 2; k++) begin
      if (arst) begin
        md[k] <= '0; mc[k] <= '0; mv[k] <= 1'b0; mrem[k] <= 0; mcnt[k] <= 0;
      end else if (flush) begin
        mc[k] <= '0; mv[k] <= 1'b0;
        mcnt[k] <= (mcnt[k] < mmax[k]) ? mcnt[k] + 1 : mcnt[k];
        mrem[k] <= mfc[k] - 1;
      end else if (mrem[k] > 0) begin
        if (!stall) begin
          mc[k] <= '0; mv[k] <= 1'b0;
          mcnt[k] <= (mcnt[k] < mmax[k]) ? mcnt[k] + 1 : mcnt[k];
          mrem[k] <= mrem[k] - 1;
        end
      end else if (!stall) begin
        md[k] <= (int'(sel) < mN[k]) ? ld[sel] : ld[0];
        mv[k] <= valid;
        mc[k] <= !valid ? 8'h00 : ((int'(sel) < mN[k]) ? lc[sel] : lc[0]);
      end
    end
  end

  always @(negedge clk) begin
    chk("A data",     bus_a.out_data,   md[0]);
    chk("A ctrl",     bus_a.out_ctrl,   mc[0]);
    chk("A valid",    bus_a.out_valid,  mv[0]);
    chk("A flushing", bus_a.flushing,   mrem[0] > 0);
    chk("A cnt",      bus_a.bubble_cnt, mcnt[0]);
    chk("B data",     bus_b.out_data,   md[1]);
    chk("B ctrl",     bus_b.out_ctrl,   mc[1]);
    chk("B valid",    bus_b.out_valid,  mv[1]);
    chk("B flushing", bus_b.flushing,   mrem[1] > 0);
    chk("B cnt",      bus_b.bubble_cnt, mcnt[1]);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    arst = 1'b1;
    for (int i = 0; i < 4; i++) begin ld[i] = '0; lc[i] = '0; end
    sel = '0; valid = 1'b0; stall = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset valid", bus_a.out_valid, 0);
    chk("reset cnt",   bus_a.bubble_cnt, 0);
    arst = 1'b0;

    // Asynchronous reset between edges
    ld[1] = 16'h1234; lc[1] = 8'h05; sel = 2'd1; valid = 1'b1;
    @(negedge clk);
    chk("lane1 data", bus_a.out_data, 16'h1234);
    chk("lane1 ctrl", bus_a.out_ctrl, 8'h05);
    #2 arst = 1'b1;
    #1;
    chk("async rst data",  bus_a.out_data,  0);
    chk("async rst ctrl",  bus_a.out_ctrl,  0);
    chk("async rst valid", bus_a.out_valid, 0);
    chk("async rst B data", bus_b.out_data, 0);
    @(negedge clk);
    arst = 1'b0;

    // Select and one-cycle latency
    ld[2] = 16'hBEEF; lc[2] = 8'h81; sel = 2'd2; valid = 1'b1;
    @(negedge clk);
    chk("sel2 data",  bus_a.out_data,  16'hBEEF);
    chk("sel2 ctrl",  bus_a.out_ctrl,  8'h81);
    chk("sel2 valid", bus_a.out_valid, 1);
    ld[3] = 16'h3333; lc[3] = 8'h33; ld[0] = 16'h0A0A; lc[0] = 8'h0C; sel = 2'd3;
    @(negedge clk);
    chk("sel3 A data",        bus_a.out_data, 16'h3333);
    chk("sel3 B fallback",    bus_b.out_data, 16'h0A0A);
    chk("sel3 B fallback ctl", bus_b.out_ctrl, 8'h0C);

    // Load with in_valid low zeroes ctrl, keeps data
    valid = 1'b0; sel = 2'd0;
    @(negedge clk);
    chk("invalid ctrl",  bus_a.out_ctrl,  0);
    chk("invalid valid", bus_a.out_valid, 0);
    chk("invalid cnt",   bus_a.bubble_cnt, 0);

    // Stall
    ld[0] = 16'h1111; lc[0] = 8'h11; valid = 1'b1;
    @(negedge clk);
    chk("pre-stall data", bus_a.out_data, 16'h1111);
    stall = 1'b1; ld[0] = 16'h2222; lc[0] = 8'h22;
    repeat (3) begin
      @(negedge clk);
      chk("stall hold", bus_a.out_data, 16'h1111);
    end
    stall = 1'b0;
    @(negedge clk);
    chk("post-stall data", bus_a.out_data, 16'h2222);

    // Isolated flush: two bubbles on A, one on B
    ld[0] = 16'h4444; lc[0] = 8'h44; flush = 1'b1;
    @(negedge clk);
    chk("flush1 valid",    bus_a.out_valid, 0);
    chk("flush1 ctrl",     bus_a.out_ctrl,  0);
    chk("flush1 data hold", bus_a.out_data, 16'h2222);
    chk("flush1 flushing", bus_a.flushing,  1);
    chk("flush1 cnt",      bus_a.bubble_cnt, 1);
    chk("flush1 B flushing", bus_b.flushing, 0);
    flush = 1'b0;
    @(negedge clk);
    chk("flush2 valid",    bus_a.out_valid, 0);
    chk("flush2 flushing", bus_a.flushing,  0);
    chk("flush2 cnt",      bus_a.bubble_cnt, 2);
    chk("flush2 B load",   bus_b.out_data,  16'h4444);
    @(negedge clk);
    chk("flush3 load data", bus_a.out_data,  16'h4444);
    chk("flush3 load ctrl", bus_a.out_ctrl,  8'h44);

    // Flush then stall inside FLUSH
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; stall = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("fstall cnt",      bus_a.bubble_cnt, 3);
      chk("fstall flushing", bus_a.flushing,   1);
    end
    stall = 1'b0;
    @(negedge clk);
    chk("fstall end cnt",      bus_a.bubble_cnt, 4);
    chk("fstall end flushing", bus_a.flushing,   0);
    @(negedge clk);
    chk("fstall reload valid", bus_a.out_valid, 1);

    // Re-flush while in FLUSH: 1 + FLUSH_CYCLES bubbles
    flush = 1'b1;
    repeat (2) @(negedge clk);
    chk("reflush flushing", bus_a.flushing, 1);
    flush = 1'b0;
    @(negedge clk);
    chk("reflush cnt",   bus_a.bubble_cnt, 7);
    chk("reflush valid", bus_a.out_valid,  0);
    @(negedge clk);
    chk("reflush load", bus_a.out_valid, 1);

    // Saturation of the 3-bit counter
    repeat (10) begin
      flush = 1'b1; @(negedge clk);
      flush = 1'b0; @(negedge clk);
    end
    chk("sat B cnt", bus_b.bubble_cnt, 7);
    chk("A cnt 27",  bus_a.bubble_cnt, 27);

    // Reset aborts a flush in progress
    flush = 1'b1;
    @(negedge clk);
    chk("abort pre flushing", bus_a.flushing, 1);
    flush = 1'b0;
    #2 arst = 1'b1;
    #1;
    chk("abort flushing", bus_a.flushing,   0);
    chk("abort A cnt",    bus_a.bubble_cnt, 0);
    chk("abort B cnt",    bus_b.bubble_cnt, 0);
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    chk("abort resume", bus_a.out_valid, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
